// File: rtl/imm_fmt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imm_fmt_pkg
// Description : Shared definitions for the immediate encoder and the
//               immediate sign extender. It holds the ctrl format codes,
//               the immediate field positions, the encoder state type and
//               small helper functions.
// Revision    : 1.0 - initial release
// ============================================================================
package imm_fmt_pkg;

    // Format codes. The sign extender decodes the same values.
    localparam logic [2:0] FMT_I    = 3'b000;
    localparam logic [2:0] FMT_D    = 3'b001;
    localparam logic [2:0] FMT_CBZ  = 3'b010;
    localparam logic [2:0] FMT_B    = 3'b011;
    localparam logic [2:0] FMT_MOVZ = 3'b100;

    // Field positions inside the 26-bit immediate.
    localparam int I_LSB         = 10;
    localparam int I_MSB         = 21;
    localparam int D_LSB         = 12;
    localparam int D_MSB         = 20;
    localparam int CBZ_LSB       = 5;
    localparam int CBZ_MSB       = 23;
    localparam int B_LSB         = 0;
    localparam int B_MSB         = 25;
    localparam int MOVZ_HW_LSB   = 21;
    localparam int MOVZ_HW_MSB   = 22;
    localparam int MOVZ_HALF_LSB = 5;
    localparam int MOVZ_HALF_MSB = 20;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    // True when the value is a sign extension of its low 'width' bits.
    // All bits from width-1 upward must be copies of one another.
    function automatic logic sext_fits(input logic [63:0] value, input int width);
        logic [63:0] hi;
        hi = 64'($signed(value) >>> (width - 1));
        return (hi == '0) || (hi == '1);
    endfunction

    // Index of the lowest set bit of a halfword mask (0 when the mask is empty).
    function automatic logic [1:0] lowest_idx(input logic [3:0] mask);
        logic [1:0] idx;
        if (mask[0])      idx = 2'd0;
        else if (mask[1]) idx = 2'd1;
        else if (mask[2]) idx = 2'd2;
        else if (mask[3]) idx = 2'd3;
        else              idx = 2'd0;
        return idx;
    endfunction

    // MOVZ/MOVK immediate: shift index in [22:21], halfword in [20:5].
    function automatic logic [25:0] movz_field(input logic [1:0] idx, input logic [15:0] half);
        logic [25:0] f;
        f = '0;
        f[MOVZ_HW_MSB:MOVZ_HW_LSB]     = idx;
        f[MOVZ_HALF_MSB:MOVZ_HALF_LSB] = half;
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/imm_fit_pack.sv
`default_nettype none
// ============================================================================
// Module      : imm_fit_pack
// Description : Combinational range check and field packing for the
//               single-beat formats (I, D, CBZ and B). For MOVZ and for the
//               unsupported codes it reports o_fits = 0 and o_imm = 0. The
//               encoder builds MOVZ beats itself.
// Ports       : i_value  - 64-bit value to encode
//               i_ctrl   - format code
//               o_imm    - packed immediate (zero unless o_fits)
//               o_fits   - value is representable in the selected format
// Revision    : 1.0 - initial release
// ============================================================================
module imm_fit_pack
    import imm_fmt_pkg::*;
(
    input  logic [63:0] i_value,
    input  logic [2:0]  i_ctrl,
    output logic [25:0] o_imm,
    output logic        o_fits
);

    always_comb begin
        o_imm  = '0;
        o_fits = 1'b0;
        case (i_ctrl)
            FMT_I: begin
                // Unsigned 12-bit field.
                o_fits = (i_value[63:12] == '0);
                if (o_fits) o_imm[I_MSB:I_LSB] = i_value[I_MSB-I_LSB:0];
            end
            FMT_D: begin
                o_fits = sext_fits(i_value, D_MSB - D_LSB + 1);
                if (o_fits) o_imm[D_MSB:D_LSB] = i_value[D_MSB-D_LSB:0];
            end
            FMT_CBZ: begin
                o_fits = sext_fits(i_value, CBZ_MSB - CBZ_LSB + 1);
                if (o_fits) o_imm[CBZ_MSB:CBZ_LSB] = i_value[CBZ_MSB-CBZ_LSB:0];
            end
            FMT_B: begin
                o_fits = sext_fits(i_value, B_MSB - B_LSB + 1);
                if (o_fits) o_imm[B_MSB:B_LSB] = i_value[B_MSB-B_LSB:0];
            end
            default: begin
                o_imm  = '0;
                o_fits = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : imm_encoder
// Description : Converts a 64-bit constant or offset into the 26-bit
//               instruction immediate that the sign extender would expand
//               back to that value. Single-beat formats produce one beat.
//               MOVZ produces one MOVZ beat followed by one MOVK beat for
//               each remaining non-zero halfword, in ascending order.
// Ports       : CLK, Reset              - clock, async active-high reset
//               ReqValid/ReqReady       - request handshake
//               ReqCtrl, ReqValue       - format code and value
//               OutValid/OutReady       - output beat handshake
//               OutImm26                - encoded immediate field
//               OutMovk, OutLast, OutErr - beat qualifiers
// Revision    : 1.0 - initial release
// ============================================================================
module imm_encoder
    import imm_fmt_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int IMM_W  = 26
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [2:0]        ReqCtrl,
    input  logic [DATA_W-1:0] ReqValue,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [IMM_W-1:0]  OutImm26,
    output logic              OutMovk,
    output logic              OutLast,
    output logic              OutErr
);

    state_t            r_state;
    logic [DATA_W-1:0] r_value;   // captured value, used for MOVK halfwords
    logic [3:0]        r_mask;    // non-zero halfwords not yet emitted
    logic [IMM_W-1:0]  r_imm;
    logic              r_movk;
    logic              r_last;
    logic              r_err;

    logic [IMM_W-1:0]  w_fit_imm;
    logic              w_fit_ok;
    logic [3:0]        w_req_nz;
    logic [1:0]        w_req_idx;
    logic [15:0]       w_req_half;
    logic [3:0]        w_req_rem;
    logic [1:0]        w_nxt_idx;
    logic [15:0]       w_nxt_half;
    logic [3:0]        w_nxt_rem;

    imm_fit_pack u_fit (
        .i_value (ReqValue),
        .i_ctrl  (ReqCtrl),
        .o_imm   (w_fit_imm),
        .o_fits  (w_fit_ok)
    );

    // First MOVZ beat: taken directly from the incoming request.
    always_comb begin
        w_req_nz = '0;
        for (int i = 0; i < 4; i++) begin
            w_req_nz[i] = |ReqValue[16*i +: 16];
        end
    end

    assign w_req_idx  = lowest_idx(w_req_nz);
    assign w_req_half = ReqValue[{w_req_idx, 4'b0000} +: 16];
    assign w_req_rem  = w_req_nz & ~(4'b0001 << w_req_idx);

    // Following MOVK beats: taken from the captured value and the pending mask.
    assign w_nxt_idx  = lowest_idx(r_mask);
    assign w_nxt_half = r_value[{w_nxt_idx, 4'b0000} +: 16];
    assign w_nxt_rem  = r_mask & ~(4'b0001 << w_nxt_idx);

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_value <= '0;
            r_mask  <= '0;
            r_imm   <= '0;
            r_movk  <= 1'b0;
            r_last  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ReqValid) begin
                        r_state <= EMIT;
                        r_value <= ReqValue;
                        r_movk  <= 1'b0;
                        if (ReqCtrl == FMT_MOVZ) begin
                            // A zero value gives an empty mask, so this is a single MOVZ #0, LSL #0 beat.
                            r_imm  <= movz_field(w_req_idx, w_req_half);
                            r_mask <= w_req_rem;
                            r_last <= (w_req_rem == 4'b0000);
                            r_err  <= 1'b0;
                        end else begin
                            r_imm  <= w_fit_ok ? w_fit_imm : '0;
                            r_mask <= '0;
                            r_last <= 1'b1;
                            r_err  <= ~w_fit_ok;
                        end
                    end
                end
                EMIT: begin
                    if (OutReady) begin
                        if (r_last) begin
                            r_state <= IDLE;
                            r_imm   <= '0;
                            r_movk  <= 1'b0;
                            r_last  <= 1'b0;
                            r_err   <= 1'b0;
                        end else begin
                            r_imm  <= movz_field(w_nxt_idx, w_nxt_half);
                            r_movk <= 1'b1;
                            r_mask <= w_nxt_rem;
                            r_last <= (w_nxt_rem == 4'b0000);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ReqReady = (r_state == IDLE);
    assign OutValid = (r_state == EMIT);
    assign OutImm26 = r_imm;
    assign OutMovk  = r_movk;
    assign OutLast  = r_last;
    assign OutErr   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_imm_encoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_imm_encoder
// Description : Self-checking bench for imm_encoder. It applies directed and
//               random requests and compares every beat against a reference
//               model built from the format rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imm_encoder;

    logic        CLK;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [2:0]  ReqCtrl;
    logic [63:0] ReqValue;
    logic        OutValid;
    logic        OutReady;
    logic [25:0] OutImm26;
    logic        OutMovk;
    logic        OutLast;
    logic        OutErr;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [25:0] imm;
        logic        movk;
        logic        last;
        logic        err;
    } beat_t;

    beat_t exp_q[$];

    imm_encoder #(.DATA_W(64), .IMM_W(26)) dut (
        .CLK      (CLK),
        .Reset    (Reset),
        .ReqValid (ReqValid),
        .ReqReady (ReqReady),
        .ReqCtrl  (ReqCtrl),
        .ReqValue (ReqValue),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutImm26 (OutImm26),
        .OutMovk  (OutMovk),
        .OutLast  (OutLast),
        .OutErr   (OutErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: the expected beats follow directly from the numeric range of each format.
    task automatic build_exp(input logic [2:0] c, input logic [63:0] v);
        longint sv;
        beat_t  b;
        bit     first;
        sv = longint'(v);
        exp_q.delete();
        b.imm = '0; b.movk = 1'b0; b.last = 1'b1; b.err = 1'b0;
        case (c)
            3'd0: if (v < 64'h1000) b.imm = 26'(v * 1024); else b.err = 1'b1;
            3'd1: if (sv >= -256 && sv <= 255) b.imm = 26'((v % 512) * 4096); else b.err = 1'b1;
            3'd2: if (sv >= -262144 && sv <= 262143) b.imm = 26'((v % 524288) * 32); else b.err = 1'b1;
            3'd3: if (sv >= -33554432 && sv <= 33554431) b.imm = 26'(v % 67108864); else b.err = 1'b1;
            3'd4: begin
                if (v == 0) begin
                    exp_q.push_back(b);
                    return;
                end
                first = 1'b1;
                for (int i = 0; i < 4; i++) begin
                    longint unsigned hw;
                    hw = (v >> (16 * i)) % 65536;
                    if (hw != 0) begin
                        beat_t m;
                        m.imm  = 26'(i * 2097152 + hw * 32);
                        m.movk = !first;
                        m.last = 1'b0;
                        m.err  = 1'b0;
                        first  = 1'b0;
                        exp_q.push_back(m);
                    end
                end
                exp_q[exp_q.size() - 1].last = 1'b1;
                return;
            end
            default: b.err = 1'b1;
        endcase
        exp_q.push_back(b);
    endtask

    task automatic check_beat(input string tag, input beat_t b);
        chk({tag, "_valid"}, OutValid, 1);
        chk({tag, "_reqready"}, ReqReady, 0);
        chk({tag, "_imm"}, OutImm26, b.imm);
        chk({tag, "_movk"}, OutMovk, b.movk);
        chk({tag, "_last"}, OutLast, b.last);
        chk({tag, "_err"}, OutErr, b.err);
    endtask

    // Issue one request, then consume every beat with 'stall' cycles of back-pressure per beat.
    task automatic do_req(input string tag, input logic [2:0] c, input logic [63:0] v, input int stall);
        int w;
        build_exp(c, v);
        w = 0;
        while (!ReqReady && w < 20) begin
            @(posedge CLK); #1;
            w++;
        end
        chk({tag, "_ready_before"}, ReqReady, 1);
        ReqValid = 1'b1;
        ReqCtrl  = c;
        ReqValue = v;
        @(posedge CLK); #1;
        ReqValid = 1'b0;
        // Changing the inputs during EMIT must have no effect.
        ReqCtrl  = 3'($urandom);
        ReqValue = {$urandom, $urandom};
        while (exp_q.size() > 0) begin
            beat_t b;
            b = exp_q.pop_front();
            for (int s = 0; s < stall; s++) begin
                OutReady = 1'b0;
                check_beat({tag, "_stall"}, b);
                @(posedge CLK); #1;
            end
            OutReady = 1'b1;
            check_beat(tag, b);
            @(posedge CLK); #1;
            OutReady = 1'b0;
        end
        chk({tag, "_done_valid"}, OutValid, 0);
        chk({tag, "_done_ready"}, ReqReady, 1);
    endtask

    function automatic logic [63:0] rand_val();
        logic [63:0] v;
        int          k;
        case ($urandom_range(0, 3))
            0: v = {$urandom, $urandom};
            1: v = 64'($signed({$urandom, $urandom}) >>> $urandom_range(36, 63));
            2: begin
                v = '0;
                for (int i = 0; i < 4; i++)
                    if ($urandom_range(0, 1) == 1) v[16*i +: 16] = 16'($urandom);
            end
            default: begin
                k = $urandom_range(7, 26);
                case ($urandom_range(0, 3))
                    0: v = (64'd1 << k);
                    1: v = (64'd1 << k) - 1;
                    2: v = -(64'd1 << k);
                    default: v = -(64'd1 << k) - 1;
                endcase
            end
        endcase
        return v;
    endfunction

    initial begin
        Reset    = 1'b1;
        ReqValid = 1'b0;
        ReqCtrl  = 3'd0;
        ReqValue = '0;
        OutReady = 1'b0;
        #1;
        chk("rst_valid", OutValid, 0);
        chk("rst_ready", ReqReady, 1);
        chk("rst_imm", OutImm26, 0);
        chk("rst_movk", OutMovk, 0);
        chk("rst_last", OutLast, 0);
        chk("rst_err", OutErr, 0);
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        Reset = 1'b0;
        @(posedge CLK); #1;

        // Directed cases.
        do_req("i_ok", 3'd0, 64'h123, 0);
        do_req("i_range", 3'd0, 64'h1000, 0);
        do_req("d_neg", 3'd1, 64'hFFFF_FFFF_FFFF_FFFC, 0);
        do_req("d_range", 3'd1, 64'h100, 0);
        do_req("cbz_max", 3'd2, 64'h3FFFF, 0);
        do_req("b_min", 3'd3, 64'hFFFF_FFFF_FE00_0000, 0);
        do_req("b_range", 3'd3, 64'h0000_0000_0200_0000, 0);
        do_req("movz_2", 3'd4, 64'h0000_1234_0000_ABCD, 0);
        do_req("movz_0", 3'd4, 64'h0, 0);
        do_req("movz_bp", 3'd4, 64'hFFFF_FFFF_FFFF_FFFF, 3);
        do_req("ctrl101", 3'd5, 64'h5, 1);

        // Random requests.
        for (int n = 0; n < 60; n++) begin
            do_req("rnd", 3'($urandom_range(0, 7)), rand_val(), $urandom_range(0, 2));
        end

        // Reset during the second beat of a 4-beat MOVZ.
        ReqValid = 1'b1;
        ReqCtrl  = 3'd4;
        ReqValue = 64'hFFFF_FFFF_FFFF_FFFF;
        @(posedge CLK); #1;
        ReqValid = 1'b0;
        OutReady = 1'b1;
        @(posedge CLK); #1;
        chk("mid_beat2_movk", OutMovk, 1);
        chk("mid_beat2_imm", OutImm26, 26'h3FFFE0);
        Reset = 1'b1;
        #1;
        chk("mid_rst_valid", OutValid, 0);
        chk("mid_rst_ready", ReqReady, 1);
        chk("mid_rst_imm", OutImm26, 0);
        @(posedge CLK); #1;
        Reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); #1;
            chk("post_rst_valid", OutValid, 0);
            chk("post_rst_ready", ReqReady, 1);
        end
        OutReady = 1'b0;

        do_req("after_rst", 3'd5, 64'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guard against a stuck run.
    initial begin
        #500000;
        $display("FAIL timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
